// File: rtl/isa_pkg.sv
// MIPS32 subset opcode/funct constants and request classes.
// Shared by the instruction encoder, its FIFO and its bench.
package isa_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = 3;

  typedef enum logic [3:0] {
    C_ADD   = 4'd0,
    C_ADDU  = 4'd1,
    C_SUB   = 4'd2,
    C_AND   = 4'd3,
    C_OR    = 4'd4,
    C_SLT   = 4'd5,
    C_MUL   = 4'd6,
    C_SEH   = 4'd7,
    C_SEB   = 4'd8,
    C_ADDI  = 4'd9,
    C_ADDIU = 4'd10,
    C_ANDI  = 4'd11,
    C_ORI   = 4'd12,
    C_XORI  = 4'd13,
    C_SLTI  = 4'd14,
    C_SLTIU = 4'd15
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SPEC2 = 6'h1C;
  localparam logic [5:0] OP_SPEC3 = 6'h1F;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MUL   = 6'h02;
  localparam logic [5:0] F_BSHFL = 6'h20;

  localparam logic [4:0] SA_SEH = 5'b11000;
  localparam logic [4:0] SA_SEB = 5'b10000;

endpackage

// File: rtl/instruction_encoder_if.sv
// Request and issue handshake bundle of the instruction encoder.
// slave: encoder side; master: request producer / word consumer side.
interface instruction_encoder_if #(
  parameter int CNT_W = 3
);

  logic             InValid;
  logic             InReady;
  logic [3:0]       InClass;
  logic [4:0]       Rs;
  logic [4:0]       Rt;
  logic [4:0]       Rd;
  logic [15:0]      Imm;
  logic             OutValid;
  logic             OutReady;
  logic [31:0]      Instr;
  logic [5:0]       OpCode;
  logic [CNT_W-1:0] Count;

  modport slave (
    input  InValid, InClass, Rs, Rt, Rd, Imm,
    input  OutReady,
    output InReady, OutValid, Instr, OpCode, Count
  );

  modport master (
    output InValid, InClass, Rs, Rt, Rd, Imm,
    output OutReady,
    input  InReady, OutValid, Instr, OpCode, Count
  );

endinterface

// File: rtl/instruction_encoder_fifo.sv
// sync_fifo: FIFO with registered head output, count and flush.
// Ports: clk, rst_n, flush, wr/din, rd, dout/valid, count, full.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, wptr_n;
  logic [PW-1:0]     rptr, rptr_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] head_n;
  logic              push, pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign valid = (count != '0);

  always_comb begin
    pop    = rd & valid;
    push   = wr & (!full | pop);
    rptr_n = pop  ? rptr + PW'(1) : rptr;
    wptr_n = push ? wptr + PW'(1) : wptr;
    cnt_n  = count;
    if (push && !pop) cnt_n = count + CNT_W'(1);
    if (pop && !push) cnt_n = count - CNT_W'(1);
    // A push lands on the new head only when the FIFO drains
    // to empty this edge; bypass it straight into the output.
    head_n = (push && wptr == rptr_n) ? din : mem[rptr_n];
    if (cnt_n == '0) head_n = '0;
    if (flush) begin
      push   = 1'b0;
      rptr_n = '0;
      wptr_n = '0;
      cnt_n  = '0;
      head_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      count <= cnt_n;
      dout  <= head_n;
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes class+field requests into MIPS32 words and queues them.
// Ports: Clk, Rst (async active-low), Flush, bus (request/issue).
module instruction_encoder
  import isa_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = FIFO_CNT_W
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Flush,
  instruction_encoder_if.slave  bus
);

  iclass_e     cls;
  logic [31:0] word;
  logic        rdy_en;
  logic        full;
  logic        accept;

  // Keeps InReady low until the first edge after reset release.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) rdy_en <= 1'b0;
    else      rdy_en <= 1'b1;
  end

  assign bus.InReady = rdy_en & !full & !Flush;
  assign accept      = bus.InValid & bus.InReady;
  assign bus.OpCode  = bus.Instr[31:26];

  always_comb begin
    cls  = iclass_e'(bus.InClass);
    word = '0;
    unique case (cls)
      C_ADD:   word = {OP_RTYPE, bus.Rs, bus.Rt, bus.Rd, 5'd0, F_ADD};
      C_ADDU:  word = {OP_RTYPE, bus.Rs, bus.Rt, bus.Rd, 5'd0, F_ADDU};
      C_SUB:   word = {OP_RTYPE, bus.Rs, bus.Rt, bus.Rd, 5'd0, F_SUB};
      C_AND:   word = {OP_RTYPE, bus.Rs, bus.Rt, bus.Rd, 5'd0, F_AND};
      C_OR:    word = {OP_RTYPE, bus.Rs, bus.Rt, bus.Rd, 5'd0, F_OR};
      C_SLT:   word = {OP_RTYPE, bus.Rs, bus.Rt, bus.Rd, 5'd0, F_SLT};
      C_MUL:   word = {OP_SPEC2, bus.Rs, bus.Rt, bus.Rd, 5'd0, F_MUL};
      C_SEH:   word = {OP_SPEC3, 5'd0, bus.Rt, bus.Rd, SA_SEH, F_BSHFL};
      C_SEB:   word = {OP_SPEC3, 5'd0, bus.Rt, bus.Rd, SA_SEB, F_BSHFL};
      C_ADDI:  word = {OP_ADDI,  bus.Rs, bus.Rt, bus.Imm};
      C_ADDIU: word = {OP_ADDIU, bus.Rs, bus.Rt, bus.Imm};
      C_ANDI:  word = {OP_ANDI,  bus.Rs, bus.Rt, bus.Imm};
      C_ORI:   word = {OP_ORI,   bus.Rs, bus.Rt, bus.Imm};
      C_XORI:  word = {OP_XORI,  bus.Rs, bus.Rt, bus.Imm};
      C_SLTI:  word = {OP_SLTI,  bus.Rs, bus.Rt, bus.Imm};
      C_SLTIU: word = {OP_SLTIU, bus.Rs, bus.Rt, bus.Imm};
    endcase
  end

  sync_fifo #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Rst),
    .flush (Flush),
    .wr    (accept),
    .din   (word),
    .rd    (bus.OutReady),
    .dout  (bus.Instr),
    .valid (bus.OutValid),
    .count (bus.Count),
    .full  (full)
  );

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder.
// Hand-computed MIPS32 words, FIFO full/flush/reset cases.
module tb_instruction_encoder;
  import isa_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic Flush = 1'b0;
  int   n_asrt = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  instruction_encoder_if #(.CNT_W(3)) bus ();

  instruction_encoder #(
    .DEPTH (4),
    .CNT_W (3)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Flush (Flush),
    .bus   (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm);
    bus.InClass = c;
    bus.Rs      = rs;
    bus.Rt      = rt;
    bus.Rd      = rd;
    bus.Imm     = imm;
    bus.InValid = 1'b1;
  endtask

  task automatic send(input logic [3:0] c, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd,
                      input logic [15:0] imm);
    bit done;
    bit ok;
    done = 0;
    drive(c, rs, rt, rd, imm);
    for (int i = 0; i < 20 && !done; i++) begin
      ok = bus.InReady;
      @(posedge Clk);
      #1;
      if (ok) done = 1;
    end
    bus.InValid = 1'b0;
    if (!done) check("accept_timeout", 32'(bus.InReady), 32'd1);
  endtask

  task automatic pop();
    bus.OutReady = 1'b1;
    @(posedge Clk);
    #1;
    bus.OutReady = 1'b0;
  endtask

  initial begin
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    bus.InClass  = '0;
    bus.Rs       = '0;
    bus.Rt       = '0;
    bus.Rd       = '0;
    bus.Imm      = '0;

    #12;
    check("rst_outvalid", 32'(bus.OutValid), 32'd0);
    check("rst_count",    32'(bus.Count),    32'd0);
    check("rst_instr",    bus.Instr,         32'd0);
    check("rst_opcode",   32'(bus.OpCode),   32'd0);
    check("rst_inready",  32'(bus.InReady),  32'd0);
    #5 Rst = 1'b1;
    #1;
    check("rel_inready_lo", 32'(bus.InReady), 32'd0);
    @(posedge Clk);
    #1;
    check("rel_inready_hi", 32'(bus.InReady), 32'd1);

    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    check("add_valid",  32'(bus.OutValid), 32'd1);
    check("add_instr",  bus.Instr,         32'h00221820);
    check("add_opcode", 32'(bus.OpCode),   32'h00);
    check("add_count",  32'(bus.Count),    32'd1);
    pop();
    check("pop_count", 32'(bus.Count),    32'd0);
    check("pop_valid", 32'(bus.OutValid), 32'd0);

    pop();
    check("idle_pop_count", 32'(bus.Count), 32'd0);

    send(4'd9, 5'd1, 5'd2, 5'd7, 16'h0005);
    check("addi_instr",  bus.Instr,       32'h20220005);
    check("addi_opcode", 32'(bus.OpCode), 32'h08);
    pop();
    send(4'd6, 5'd1, 5'd2, 5'd3, 16'h0);
    check("mul_instr", bus.Instr, 32'h70221802);
    pop();
    send(4'd7, 5'd9, 5'd5, 5'd4, 16'h0);
    check("seh_instr", bus.Instr, 32'h7C052620);
    pop();
    send(4'd8, 5'd3, 5'd6, 5'd2, 16'h0);
    check("seb_instr", bus.Instr, 32'h7C061420);
    pop();
    send(4'd13, 5'd31, 5'd0, 5'd9, 16'hFFFF);
    check("xori_instr", bus.Instr, 32'h3BE0FFFF);
    pop();
    send(4'd5, 5'd4, 5'd5, 5'd6, 16'h0);
    check("slt_instr", bus.Instr, 32'h0085302A);
    pop();

    for (int i = 1; i <= 4; i++) begin
      send(4'd12, 5'd0, 5'd1, 5'd0, 16'(i));
      check("fill_count", 32'(bus.Count), 32'(i));
    end
    check("full_inready", 32'(bus.InReady), 32'd0);
    check("full_head",    bus.Instr,        32'h34010001);
    drive(4'd12, 5'd0, 5'd1, 5'd0, 16'd5);
    @(posedge Clk);
    #1;
    check("full_wait_count", 32'(bus.Count), 32'd4);
    bus.OutReady = 1'b1;
    @(posedge Clk);
    #1;
    check("drain1_instr",   bus.Instr,        32'h34010002);
    check("drain1_count",   32'(bus.Count),   32'd3);
    check("drain1_inready", 32'(bus.InReady), 32'd1);
    @(posedge Clk);
    #1;
    bus.InValid = 1'b0;
    check("pushpop_instr", bus.Instr,      32'h34010003);
    check("pushpop_count", 32'(bus.Count), 32'd3);
    for (int i = 4; i <= 5; i++) begin
      @(posedge Clk);
      #1;
      check("drain_instr", bus.Instr, 32'h34010000 | 32'(i));
    end
    @(posedge Clk);
    #1;
    bus.OutReady = 1'b0;
    check("drained_count", 32'(bus.Count),    32'd0);
    check("drained_valid", 32'(bus.OutValid), 32'd0);

    for (int i = 0; i < 3; i++) send(4'd1, 5'(i), 5'd1, 5'd2, 16'h0);
    check("pre_flush_count", 32'(bus.Count), 32'd3);
    Flush = 1'b1;
    drive(4'd4, 5'd7, 5'd7, 5'd7, 16'h0);
    bus.OutReady = 1'b1;
    @(posedge Clk);
    #1;
    Flush        = 1'b0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    check("flush_count", 32'(bus.Count),    32'd0);
    check("flush_valid", 32'(bus.OutValid), 32'd0);
    @(posedge Clk);
    #1;
    check("flush_no_word", 32'(bus.Count), 32'd0);

    send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0);
    send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0);
    check("pre_rst_count", 32'(bus.Count), 32'd2);
    #3 Rst = 1'b0;
    #1;
    check("arst_valid",   32'(bus.OutValid), 32'd0);
    check("arst_count",   32'(bus.Count),    32'd0);
    check("arst_instr",   bus.Instr,         32'd0);
    check("arst_inready", 32'(bus.InReady),  32'd0);
    #2 Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("rerel_inready", 32'(bus.InReady), 32'd1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    check("post_rst_instr", bus.Instr,         32'h00221820);
    check("post_rst_valid", 32'(bus.OutValid), 32'd1);
    check("post_rst_count", 32'(bus.Count),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
